axi_data_check: RTL and testbench

// - AXI-stream sink/checker downstream of the incrementing-data generator.
// - Accepts one packet per arm and drives registered ready, with optional LFSR back-pressure.
// - Checks data against a free-running incrementing counter, checks keep shape and byte length.
// - Reports pass/fail plus sticky error flags and saturating packet/error counters.

---
 rtl/axi_data_pkg.sv | 39 +++
 rtl/axi_bp_lfsr.sv | 23 ++
 rtl/axi_data_check.sv | 208 ++++++++++++++++++++
 tb/tb_axi_data_check.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_data_pkg.sv
// Shared types and helpers for the AXI-stream data checker.
package axi_data_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StReport
  } state_t;

  // Upper bound on keep width handled by the helpers; callers cast to their own width.
  localparam int unsigned MaxStrb = 64;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Keep mask expected on the last beat: len_lsbs low ones, or all strb ones when zero.
  function automatic logic [MaxStrb-1:0] keep_mask(input int unsigned len_lsbs,
                                                   input int unsigned strb);
    logic [MaxStrb-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxStrb; i++) begin
      if ((len_lsbs == 0 && i < strb) || (i < len_lsbs)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

  function automatic int unsigned popcount(input logic [MaxStrb-1:0] keep);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxStrb; i++) begin
      if (keep[i]) begin
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_bp_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used to throttle ready.
module axi_bp_lfsr #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bp_bit_o
);

  logic [15:0] lfsr_q;

  // Free-running shift, one step per cycle; reseeded by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign bp_bit_o = lfsr_q[0];

endmodule

// File: rtl/axi_data_check.sv
// AXI-stream sink that checks one packet per arm against an incrementing data pattern.
module axi_data_check #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LENGTH_WIDTH   = 9,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [LENGTH_WIDTH-1:0] i_exp_length,
  input  logic                    i_bp_en,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  input  logic [STRB_WIDTH-1:0]   i_keep,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_err_data,
  output logic                    o_err_keep,
  output logic                    o_err_len,
  output logic                    o_err_timeout,
  output logic [LENGTH_WIDTH-1:0] o_byte_cnt,
  output logic [15:0]             o_pkt_cnt,
  output logic [15:0]             o_err_cnt
);
  import axi_data_pkg::*;

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SumW = LENGTH_WIDTH + 1;
  localparam logic [STRB_WIDTH-1:0] KeepFull = {STRB_WIDTH{1'b1}};
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0] exp_words_q, exp_words_d;
  logic [STRB_WIDTH-1:0]   exp_last_keep_q, exp_last_keep_d;
  logic [LENGTH_WIDTH-1:0] beat_cnt_q, beat_cnt_d, beat_inc;
  logic [WdW-1:0]          wd_q, wd_d;
  logic [DATA_WIDTH-1:0]   exp_data_q, exp_data_d;
  logic                    err_data_q, err_data_d, err_keep_q, err_keep_d;
  logic                    err_len_q, err_len_d, err_timeout_q, err_timeout_d;
  logic [LENGTH_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [SumW-1:0]         byte_sum;
  logic                    pass_q, pass_d, ready_q, ready_d, busy_q, done_q;
  logic [15:0]             pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic                    accept, last_legal, bp_bit;

  axi_bp_lfsr #(
    .Seed(LFSR_SEED)
  ) u_bp_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bp_bit_o(bp_bit)
  );

  assign accept = i_valid & ready_q;

  // Next-state, per-packet checks and report bookkeeping.
  always_comb begin
    state_d         = state_q;
    exp_words_d     = exp_words_q;
    exp_last_keep_d = exp_last_keep_q;
    beat_cnt_d      = beat_cnt_q;
    wd_d            = wd_q;
    exp_data_d      = exp_data_q;
    err_data_d      = err_data_q;
    err_keep_d      = err_keep_q;
    err_len_d       = err_len_q;
    err_timeout_d   = err_timeout_q;
    byte_cnt_d      = byte_cnt_q;
    pass_d          = pass_q;
    pkt_cnt_d       = pkt_cnt_q;
    err_cnt_d       = err_cnt_q;

    beat_inc   = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + LENGTH_WIDTH'(1);
    byte_sum   = {1'b0, byte_cnt_q} + SumW'(popcount(MaxStrb'(i_keep)));
    // Legal last-beat keep is a contiguous run of ones from bit 0.
    last_legal = (i_keep != '0) && ((i_keep & (i_keep + STRB_WIDTH'(1))) == '0);

    case (state_q)
      StIdle: begin
        if (i_start) begin
          exp_words_d     = LENGTH_WIDTH'((32'(i_exp_length) + STRB_WIDTH - 1) / STRB_WIDTH);
          exp_last_keep_d = STRB_WIDTH'(keep_mask(32'(i_exp_length) % STRB_WIDTH, STRB_WIDTH));
          beat_cnt_d      = '0;
          wd_d            = '0;
          err_data_d      = 1'b0;
          err_keep_d      = 1'b0;
          err_len_d       = 1'b0;
          err_timeout_d   = 1'b0;
          byte_cnt_d      = '0;
          pass_d          = 1'b0;
          if (i_exp_length == '0) begin
            err_len_d = 1'b1;
            state_d   = StReport;
          end else begin
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (accept) begin
          wd_d       = '0;
          beat_cnt_d = beat_inc;
          // Resync on the received word so one bad beat is not a cascade of errors.
          exp_data_d = i_data + DATA_WIDTH'(1);
          byte_cnt_d = byte_sum[LENGTH_WIDTH] ? '1 : byte_sum[LENGTH_WIDTH-1:0];
          if (i_data != exp_data_q) begin
            err_data_d = 1'b1;
          end
          if (i_last) begin
            if (!last_legal) begin
              err_keep_d = 1'b1;
            end else if (i_keep != exp_last_keep_q) begin
              err_len_d = 1'b1;
            end
            if (beat_inc != exp_words_q) begin
              err_len_d = 1'b1;
            end
            state_d = StReport;
          end else begin
            if (i_keep != KeepFull) begin
              err_keep_d = 1'b1;
            end
            // Too many beats: flag, but keep draining until the last beat.
            if (beat_inc >= exp_words_q) begin
              err_len_d = 1'b1;
            end
          end
        end else if (wd_q == WdLast) begin
          err_timeout_d = 1'b1;
          state_d       = StReport;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Result and counters are captured on entry to the report cycle.
    if (state_d == StReport) begin
      pass_d    = ~(err_data_d | err_keep_d | err_len_d | err_timeout_d);
      pkt_cnt_d = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
      if (!pass_d && err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end

    ready_d = (state_d == StRecv) && (i_bp_en ? bp_bit : 1'b1);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      exp_words_q     <= '0;
      exp_last_keep_q <= '0;
      beat_cnt_q      <= '0;
      wd_q            <= '0;
      exp_data_q      <= '0;
      err_data_q      <= 1'b0;
      err_keep_q      <= 1'b0;
      err_len_q       <= 1'b0;
      err_timeout_q   <= 1'b0;
      byte_cnt_q      <= '0;
      pass_q          <= 1'b0;
      pkt_cnt_q       <= '0;
      err_cnt_q       <= '0;
      ready_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      exp_words_q     <= exp_words_d;
      exp_last_keep_q <= exp_last_keep_d;
      beat_cnt_q      <= beat_cnt_d;
      wd_q            <= wd_d;
      exp_data_q      <= exp_data_d;
      err_data_q      <= err_data_d;
      err_keep_q      <= err_keep_d;
      err_len_q       <= err_len_d;
      err_timeout_q   <= err_timeout_d;
      byte_cnt_q      <= byte_cnt_d;
      pass_q          <= pass_d;
      pkt_cnt_q       <= pkt_cnt_d;
      err_cnt_q       <= err_cnt_d;
      ready_q         <= ready_d;
      busy_q          <= (state_d != StIdle);
      done_q          <= (state_d == StReport);
    end
  end

  assign o_ready       = ready_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_err_data    = err_data_q;
  assign o_err_keep    = err_keep_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_timeout_q;
  assign o_byte_cnt    = byte_cnt_q;
  assign o_pkt_cnt     = pkt_cnt_q;
  assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_axi_data_check.sv
// Randomized self-checking bench for axi_data_check with a packet-level reference model.
module tb_axi_data_check;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 9;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 1024;

  logic          clk = 1'b0;
  logic          rst_n, i_start, i_bp_en, i_valid, i_last;
  logic [LW-1:0] i_exp_length;
  logic [DW-1:0] i_data;
  logic [SW-1:0] i_keep;
  logic          o_ready, o_busy, o_done, o_pass;
  logic          o_err_data, o_err_keep, o_err_len, o_err_timeout;
  logic [LW-1:0] o_byte_cnt;
  logic [15:0]   o_pkt_cnt, o_err_cnt;

  always #5 clk = ~clk;

  axi_data_check #(
    .DATA_WIDTH    (DW),
    .LENGTH_WIDTH  (LW),
    .STRB_WIDTH    (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_exp_length (i_exp_length),
    .i_bp_en      (i_bp_en),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_keep       (i_keep),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_err_data   (o_err_data),
    .o_err_keep   (o_err_keep),
    .o_err_len    (o_err_len),
    .o_err_timeout(o_err_timeout),
    .o_byte_cnt   (o_byte_cnt),
    .o_pkt_cnt    (o_pkt_cnt),
    .o_err_cnt    (o_err_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: upstream generator, checker expectation, packet counters.
  logic [DW-1:0] gen;
  logic [DW-1:0] mdl_exp;
  int            mdl_pkts;
  int            mdl_errs;
  logic [DW-1:0] bd[$];
  logic [SW-1:0] bk[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] tail_keep(input int nbytes);
    case (nbytes % 4)
      0:       return 4'hF;
      1:       return 4'h1;
      2:       return 4'h3;
      default: return 4'h7;
    endcase
  endfunction

  // Builds a clean generator packet of nbytes into bd/bk.
  task automatic build_pkt(input int nbytes);
    int nb;
    bd.delete();
    bk.delete();
    nb = (nbytes + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      bd.push_back(gen);
      gen = gen + 32'd1;
      bk.push_back((i == nb - 1) ? tail_keep(nbytes) : 4'hF);
    end
  endtask

  task automatic arm(input int exp_len, input bit bp);
    i_start      = 1'b1;
    i_exp_length = LW'(exp_len);
    i_bp_en      = bp;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Arms, streams bd/bk, and checks the report against the model.
  task automatic run_pkt(input int exp_len, input bit bp, input bit gaps, input bit stray);
    int            n, idx, cyc, bytes;
    bit            e_data, e_keep, e_len, e_pass, legal, rdy;
    logic [SW-1:0] lk;
    logic          r0;
    n      = bd.size();
    e_data = 0;
    e_keep = 0;
    bytes  = 0;
    for (int i = 0; i < n; i++) begin
      if (bd[i] != mdl_exp) e_data = 1;
      mdl_exp = bd[i] + 32'd1;
      bytes += $countones(bk[i]);
      if (i != n - 1 && bk[i] != 4'hF) e_keep = 1;
    end
    lk    = bk[n-1];
    legal = lk inside {4'h1, 4'h3, 4'h7, 4'hF};
    if (!legal) e_keep = 1;
    e_len  = (n != (exp_len + 3) / 4) || (legal && lk != tail_keep(exp_len));
    if (bytes > 511) bytes = 511;
    e_pass = !(e_data || e_keep || e_len);
    if (mdl_pkts < 65535) mdl_pkts++;
    if (!e_pass && mdl_errs < 65535) mdl_errs++;

    arm(exp_len, bp);
    check_eq("busy_after_arm", o_busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < n) begin
      r0      = o_ready;
      i_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      i_data  = bd[idx];
      i_keep  = bk[idx];
      i_last  = (idx == n - 1);
      if (stray) begin
        i_start      = ($urandom_range(7) == 0);
        i_exp_length = LW'($urandom);
      end
      #1;
      if (bp) check_eq("ready_vs_valid", o_ready, r0);
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      if (rdy && i_valid) idx++;
      #1;
      cyc++;
      if (cyc > 4000) begin
        check_eq("beat_budget", idx, n);
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_start = 1'b0;
    check_eq("done_latency", o_done, 1);
    check_eq("ready_drop", o_ready, 0);
    check_eq("pass", o_pass, e_pass);
    check_eq("err_data", o_err_data, e_data);
    check_eq("err_keep", o_err_keep, e_keep);
    check_eq("err_len", o_err_len, e_len);
    check_eq("err_timeout", o_err_timeout, 0);
    check_eq("byte_cnt", o_byte_cnt, bytes);
    check_eq("pkt_cnt", o_pkt_cnt, mdl_pkts);
    check_eq("err_cnt", o_err_cnt, mdl_errs);
    @(posedge clk);
    #1;
    check_eq("done_pulse", o_done, 0);
    check_eq("idle_busy", o_busy, 0);
    check_eq("pass_hold", o_pass, e_pass);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {o_ready, o_busy, o_done, o_pass, o_err_data, o_err_keep, o_err_len,
                   o_err_timeout, o_byte_cnt, o_pkt_cnt, o_err_cnt}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, elen, nbytes;
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_exp_length = '0;
    i_bp_en      = 1'b0;
    i_valid      = 1'b0;
    i_data       = '0;
    i_keep       = '0;
    i_last       = 1'b0;
    gen          = '0;
    mdl_exp      = '0;
    mdl_pkts     = 0;
    mdl_errs     = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: len 10 then len 8, no back-pressure.
    build_pkt(10);
    run_pkt(10, 0, 0, 0);
    check_eq("first_bytes", o_byte_cnt, 10);
    build_pkt(8);
    run_pkt(8, 0, 0, 0);
    check_eq("second_pkts", o_pkt_cnt, 2);

    // Back-pressure, 16 beats.
    build_pkt(64);
    run_pkt(64, 1, 0, 0);

    // Corrupted middle beat, then a clean packet after resync.
    build_pkt(12);
    bd[1] = 32'hDEAD;
    run_pkt(12, 0, 0, 0);
    check_eq("dead_err_cnt", o_err_cnt, 1);
    build_pkt(8);
    run_pkt(8, 0, 0, 0);
    check_eq("resync_pass", o_pass, 1);

    // Length and keep faults.
    build_pkt(12);
    run_pkt(10, 0, 0, 0);
    build_pkt(10);
    bk[2] = 4'h5;
    run_pkt(10, 0, 0, 0);
    build_pkt(10);
    bk[0] = 4'h7;
    run_pkt(10, 0, 0, 0);

    // Stray beat in idle must not be taken.
    i_valid = 1'b1;
    i_data  = 32'h1234_5678;
    i_keep  = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_ready", o_ready, 0);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;

    // Randomized packets with gaps, faults, stray arms and random back-pressure.
    for (int p = 0; p < 24; p++) begin
      elen   = $urandom_range(40, 1);
      nbytes = ($urandom_range(3) == 0) ? elen + 1 + $urandom_range(7) : elen;
      build_pkt(nbytes);
      if ($urandom_range(4) == 0) bd[$urandom_range(bd.size() - 1)] = $urandom;
      if ($urandom_range(4) == 0) bk[$urandom_range(bk.size() - 1)] = SW'($urandom_range(15));
      run_pkt(elen, 1'($urandom_range(1)), 1, 1);
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    // Zero length goes straight to report.
    arm(0, 0);
    mdl_pkts++;
    mdl_errs++;
    check_eq("zero_len_done", o_done, 1);
    check_eq("zero_len_err", o_err_len, 1);
    check_eq("zero_len_pass", o_pass, 0);
    check_eq("zero_len_pkts", o_pkt_cnt, mdl_pkts);
    @(posedge clk);
    #1;

    // Watchdog with no traffic.
    arm(8, 1'($urandom_range(1)));
    mdl_pkts++;
    mdl_errs++;
    cyc = 0;
    while (!o_done && cyc < int'(TO) + 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("timeout_latency", cyc, TO);
    check_eq("timeout_flag", o_err_timeout, 1);
    check_eq("timeout_pass", o_pass, 0);
    check_eq("timeout_bytes", o_byte_cnt, 0);
    check_eq("timeout_err_cnt", o_err_cnt, mdl_errs);
    @(posedge clk);
    #1;

    // Reset mid-packet.
    arm(8, 0);
    i_valid = 1'b1;
    i_data  = gen;
    i_keep  = 4'hF;
    i_last  = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check_eq("mid_bytes", o_byte_cnt, 4);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("mid_reset_outputs");
    rst_n    = 1'b1;
    gen      = '0;
    mdl_exp  = '0;
    mdl_pkts = 0;
    mdl_errs = 0;
    @(posedge clk);
    #1;
    build_pkt(6);
    run_pkt(6, 0, 0, 0);
    check_eq("post_reset_pkts", o_pkt_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
